cnt_arb_seq: RTL

- Shares one WIDTH-bit up/down counter between two requesters.
- Each requester asks for a run of N count steps in a chosen direction.
- The block arbitrates round-robin, sequences the count-enable and direction controls cycle by cycle, and reports completion.
- Sits directly above the ripple up/down counter; it is the only driver of that counter's count, inc and reset controls.

---
 rtl/cnt_pkg.sv | 22 ++
 rtl/updown_cnt.sv | 43 ++++
 rtl/cnt_arb_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared types and constants for the counter arbiter/sequencer and its counter.
package cnt_pkg;

    localparam int CNT_WIDTH_DEF = 3;
    localparam int CNT_SW_DEF    = 4;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // One-hot pulse vector addressed to a single requester.
    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/updown_cnt.sv
// WIDTH-bit synchronous up/down counter built from a chain of toggle cells.
// inc = 0 counts up, inc = 1 counts down. Reset and clear are folded into
// each bit's D input. cout is the toggle carried out of the top cell, so it
// is high only on the step that wraps.
module updown_cnt
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             clr,
    input  logic             count,
    input  logic             inc,
    output logic [WIDTH-1:0] q,
    output logic             cout
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   tgl;

    // Per-bit cells: a bit toggles when every lower bit passes the carry
    // (all ones going up, all zeros going down).
    always_comb begin
        tgl    = '0;
        q_d    = '0;
        tgl[0] = count;
        for (int i = 0; i < WIDTH; i++) begin
            tgl[i+1] = tgl[i] & (q_q[i] ^ inc);
            q_d[i]   = reset_ & ~clr & (q_q[i] ^ tgl[i]);
        end
    end

    // Counter register; reset/clear already gated into q_d.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q    = q_q;
    assign cout = tgl[WIDTH];

endmodule

// File: rtl/cnt_arb_seq.sv
// Round-robin arbiter and run sequencer for a shared up/down counter.
// Optional build macro CNT_SAT_EN: a run stops instead of wrapping and raises sat.
//
// state | meaning
// IDLE  | waiting; clr zeroes the counter, otherwise pick a requester
// LOAD  | grant pulse, capture owner direction and step count
// RUN   | one counter step per cycle until the run is exhausted
// FIN   | done pulse to owner, hand round-robin priority to the other side
module cnt_arb_seq
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF,
    parameter int SW    = CNT_SW_DEF
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [SW-1:0]    steps0,
    input  logic [SW-1:0]    steps1,
    input  logic             clr,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             sat
);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            cur_dir_q, cur_dir_d;
    logic [SW-1:0]   remaining_q, remaining_d;
    logic            rr_q, rr_d;
    logic            sat_q, sat_d;

    logic            cnt_count;
    logic            cnt_inc;
    logic            cnt_clr;
    logic [1:0]      gnt_c;
    logic [1:0]      done_c;
    logic            sat_stop;

`ifdef CNT_SAT_EN
    assign sat_stop = (cur_dir_q == DIR_UP) ? (&q) : ~(|q);
`else
    assign sat_stop = 1'b0;
`endif

    // Next-state, datapath updates and counter controls.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cur_dir_d   = cur_dir_q;
        remaining_d = remaining_q;
        rr_d        = rr_q;
        sat_d       = sat_q;
        cnt_count   = 1'b0;
        cnt_inc     = cur_dir_q;
        cnt_clr     = 1'b0;
        gnt_c       = 2'b00;
        done_c      = 2'b00;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    cnt_clr = 1'b1;
                end else if (req != 2'b00) begin
                    owner_d = (req == 2'b11) ? rr_q : req[1];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                gnt_c       = onehot2(owner_q);
                cur_dir_d   = dir[owner_q];
                remaining_d = owner_q ? steps1 : steps0;
                sat_d       = 1'b0;
                state_d     = (remaining_d == '0) ? FIN : RUN;
            end
            RUN: begin
                if (sat_stop) begin
                    sat_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_count   = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == SW'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done_c  = onehot2(owner_q);
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cur_dir_q   <= DIR_UP;
            remaining_q <= '0;
            rr_q        <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cur_dir_q   <= cur_dir_d;
            remaining_q <= remaining_d;
            rr_q        <= rr_d;
            sat_q       <= sat_d;
        end
    end

    // Pulses are suppressed while reset is asserted, whatever state is held.
    assign gnt  = reset_ ? gnt_c  : 2'b00;
    assign done = reset_ ? done_c : 2'b00;
    assign busy = (state_q != IDLE);
    assign sat  = sat_q;

    updown_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .clr    (cnt_clr),
        .count  (cnt_count),
        .inc    (cnt_inc),
        .q      (q),
        .cout   (cout)
    );

endmodule
